// File: rtl/pulse_stretcher_if.sv
// pulse_stretcher_if: event strobe toward the stretcher, conditioned line and queue status back.
interface pulse_stretcher_if #(parameter int MAX_PENDING = 7);
    logic trigger, out, busy, overflow;
    logic [$clog2(MAX_PENDING+1)-1:0] pending;
    modport master(output trigger, input out, busy, pending, overflow);
    modport slave(input trigger, output out, busy, pending, overflow);
endinterface

// File: rtl/pulse_stretcher.sv
// pulse_stretcher: turns single-cycle strobes into fixed-width pulses with a minimum low gap, queueing bursts.
module pulse_stretcher #(
    parameter int ON_CYCLES = 512,
    parameter int OFF_CYCLES = 512,
    parameter int MAX_PENDING = 7
) (
    input logic clk,
    input logic reset,
    pulse_stretcher_if.slave io
);
    localparam int CMAX = ON_CYCLES > OFF_CYCLES ? ON_CYCLES : OFF_CYCLES;
    localparam int CW = $clog2(CMAX + 1);
    localparam int PW = $clog2(MAX_PENDING + 1);
    localparam logic [CW-1:0] ON_LAST = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] OFF_LAST = CW'(OFF_CYCLES - 1);
    localparam logic [PW-1:0] PMAX = PW'(MAX_PENDING);
    typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;
    state_t state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [PW-1:0] pend, pend_d;
    logic ovf, ovf_d, out_q, enq, deq;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            pend <= '0;
            ovf <= 1'b0;
            out_q <= 1'b0;
        end else begin
            state <= state_d;
            cnt <= cnt_d;
            pend <= pend_d;
            ovf <= ovf_d;
            out_q <= state_d == HIGH;
        end
    end
    always_comb begin
        state_d = state;
        cnt_d = '0;
        deq = 1'b0;
        // an idle trigger with nothing queued starts the pulse directly instead of queueing
        enq = io.trigger && !(state == IDLE && pend == '0);
        if (state == IDLE) begin
            deq = pend != '0;
            state_d = (deq || io.trigger) ? HIGH : IDLE;
        end else if (state == HIGH) begin
            state_d = cnt == ON_LAST ? GAP : HIGH;
            cnt_d = cnt == ON_LAST ? '0 : cnt + 1'b1;
        end else begin
            deq = cnt == OFF_LAST && pend != '0;
            state_d = cnt != OFF_LAST ? GAP : deq ? HIGH : IDLE;
            cnt_d = cnt == OFF_LAST ? '0 : cnt + 1'b1;
        end
        pend_d = pend;
        ovf_d = ovf;
        if (enq && !deq) begin
            if (pend == PMAX) ovf_d = 1'b1;
            else pend_d = pend + 1'b1;
        end else if (deq && !enq) begin
            pend_d = pend - 1'b1;
        end
    end
    assign io.out = out_q;
    assign io.busy = state != IDLE;
    assign io.pending = pend;
    assign io.overflow = ovf;
endmodule

// File: tb/tb_pulse_stretcher.sv
// tb_pulse_stretcher: directed scenarios; expected pulse start cycles are queued and matched by a monitor.
module tb_pulse_stretcher;
    localparam int ON = 4, OFF = 3, MAXP = 2;
    logic clk = 1'b0, reset = 1'b1;
    int cyc = 0, checks = 0, errors = 0;
    int exp_q[$];
    pulse_stretcher_if #(.MAX_PENDING(MAXP)) io();
    pulse_stretcher #(.ON_CYCLES(ON), .OFF_CYCLES(OFF), .MAX_PENDING(MAXP)) dut (
        .clk(clk), .reset(reset), .io(io)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual %0d required %0d", name, cyc, act, req);
        end
    endtask

    task automatic go(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        io.trigger = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_out", int'(io.out), 0);
        chk("rst_busy", int'(io.busy), 0);
        chk("rst_pending", int'(io.pending), 0);
        chk("rst_overflow", int'(io.overflow), 0);
        go(cyc + 3);
    endtask

    task automatic trig(input int n);
        io.trigger = 1'b1;
        repeat (n) @(negedge clk);
        io.trigger = 1'b0;
    endtask

    // monitor: one sample per cycle, just after the edge
    logic out_prev = 1'b0;
    bit abort = 1'b1;
    int rise_c = -1, fall_c = -1;
    always @(posedge clk) begin
        #1;
        if (reset) begin
            abort = 1'b1;
            fall_c = -1;
        end
        if (!out_prev && io.out) begin
            if (exp_q.size() == 0) chk("unexpected_pulse", cyc, -1);
            else chk("pulse_start", cyc, exp_q.pop_front());
            if (fall_c >= 0 && cyc - fall_c < OFF) chk("low_gap", cyc - fall_c, OFF);
            rise_c = cyc;
            abort = 1'b0;
        end
        if (out_prev && !io.out) begin
            if (!abort) chk("pulse_width", cyc - rise_c, ON);
            fall_c = cyc;
        end
        out_prev = io.out;
    end

    int b;
    initial begin
        io.trigger = 1'b0;
        @(negedge clk);
        do_reset();
        // single event
        b = cyc;
        exp_q.push_back(b + 1);
        trig(1);
        go(b + 7);
        chk("single_busy_hi", int'(io.busy), 1);
        chk("single_pending", int'(io.pending), 0);
        go(b + 8);
        chk("single_busy_lo", int'(io.busy), 0);
        go(b + 12);
        // held trigger, three cycles
        do_reset();
        b = cyc;
        exp_q.push_back(b + 1); exp_q.push_back(b + 8); exp_q.push_back(b + 15);
        trig(3);
        chk("held_pend2", int'(io.pending), 2);
        go(b + 8);
        chk("held_pend1", int'(io.pending), 1);
        go(b + 15);
        chk("held_pend0", int'(io.pending), 0);
        chk("held_ovf", int'(io.overflow), 0);
        go(b + 21);
        chk("held_busy_last", int'(io.busy), 1);
        go(b + 22);
        chk("held_idle", int'(io.busy), 0);
        // overflow, five cycles
        do_reset();
        b = cyc;
        exp_q.push_back(b + 1); exp_q.push_back(b + 8); exp_q.push_back(b + 15);
        io.trigger = 1'b1;
        go(b + 3);
        chk("ovf_before", int'(io.overflow), 0);
        go(b + 4);
        chk("ovf_set", int'(io.overflow), 1);
        chk("ovf_pend_sat", int'(io.pending), 2);
        go(b + 5);
        io.trigger = 1'b0;
        go(b + 22);
        chk("ovf_idle", int'(io.busy), 0);
        go(b + 30);
        chk("ovf_sticky", int'(io.overflow), 1);
        // simultaneous dequeue and enqueue while saturated
        do_reset();
        b = cyc;
        exp_q.push_back(b + 1); exp_q.push_back(b + 8);
        exp_q.push_back(b + 15); exp_q.push_back(b + 22);
        trig(3);
        go(b + 7);
        chk("sim_pend_before", int'(io.pending), 2);
        trig(1);
        chk("sim_pend_kept", int'(io.pending), 2);
        chk("sim_ovf", int'(io.overflow), 0);
        go(b + 15);
        chk("sim_pend1", int'(io.pending), 1);
        go(b + 22);
        chk("sim_pend0", int'(io.pending), 0);
        go(b + 29);
        chk("sim_idle", int'(io.busy), 0);
        // reset during the second high cycle with one event queued
        do_reset();
        b = cyc;
        exp_q.push_back(b + 1);
        trig(2);
        chk("mid_pend1", int'(io.pending), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_out", int'(io.out), 0);
        chk("mid_busy", int'(io.busy), 0);
        chk("mid_pending", int'(io.pending), 0);
        chk("mid_overflow", int'(io.overflow), 0);
        go(b + 25);
        // trigger on the last gap cycle with nothing queued
        do_reset();
        b = cyc;
        exp_q.push_back(b + 1); exp_q.push_back(b + 9);
        trig(1);
        go(b + 7);
        trig(1);
        chk("gb_idle", int'(io.busy), 0);
        chk("gb_pend1", int'(io.pending), 1);
        @(negedge clk);
        chk("gb_busy", int'(io.busy), 1);
        chk("gb_pend0", int'(io.pending), 0);
        chk("gb_ovf", int'(io.overflow), 0);
        go(b + 25);
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
- Output-side counterpart to input debouncing.
- Takes single-cycle internal event strobes and drives a physical-facing line (LED, buzzer, strobe pin) with a guaranteed minimum high time and a minimum low gap between pulses.
- Bursts of events arriving faster than the line can show them are queued in a saturating pending counter. Nothing is silently lost unless an overflow flag is raised.
- Sits between core control logic and top-level output pins.

Parameters:
- ON_CYCLES, 512, length of each output high pulse in clk cycles; must be >= 1.
- OFF_CYCLES, 512, minimum low gap after each pulse, in clk cycles; must be >= 1.
- MAX_PENDING, 7, maximum number of queued events; must be >= 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- trigger  input  1  event strobe, sampled every cycle; a high cycle counts as one event.
- out  output  1  conditioned output line, registered.
- busy  output  1  high whenever state != IDLE.
- pending  output  $clog2(MAX_PENDING+1)  number of queued events not yet started.
- overflow  output  1  sticky; set when an event is dropped, cleared only by reset.

Behaviour:
- States: IDLE, HIGH, GAP. One phase counter of width $clog2(max(ON_CYCLES,OFF_CYCLES)+1).
- Reset (synchronous, priority over everything):
  - state=IDLE, counter=0, pending=0, overflow=0, out=0.
  - Outputs take these values the cycle after reset is sampled high.
  - Reset mid-pulse or mid-gap aborts immediately, and queued events are discarded.
  - A trigger in the same cycle as reset is ignored.
- IDLE:
  - out=0.
  - trigger=1 -> HIGH next cycle, counter=0; the event is not counted in pending.
- HIGH:
  - out=1.
  - Counter increments each cycle.
  - After exactly ON_CYCLES cycles in HIGH -> GAP, counter=0.
- GAP:
  - out=0.
  - Counter increments each cycle.
  - After exactly OFF_CYCLES cycles in GAP:
    - pending>0 -> HIGH, counter=0, pending decrements.
    - pending==0 -> IDLE.
- Latency: trigger sampled in IDLE at edge t -> out=1 from edge t+1 for ON_CYCLES cycles.
- Queueing:
  - trigger=1 while busy increments pending.
  - If pending==MAX_PENDING, the event is dropped and overflow<=1.
- Simultaneous trigger and dequeue (last GAP cycle with pending>0): pending is unchanged, not decremented; no overflow even when saturated.
- Last GAP cycle with pending==0 and trigger=1: the event is recorded as pending=1 and the FSM goes to IDLE. Next cycle IDLE sees pending>0 and goes to HIGH with pending decremented.
  - Rule: IDLE with pending>0 -> HIGH, pending-1, regardless of trigger.
  - A trigger in that same IDLE cycle is counted into pending.
- Timing guarantees:
  - Back-to-back pulses are always separated by at least OFF_CYCLES low cycles.
  - Every pulse is exactly ON_CYCLES wide.
- Counter arithmetic never wraps; comparisons are against ON_CYCLES-1 and OFF_CYCLES-1.
- busy=1 in HIGH and GAP, 0 in IDLE.
- out is driven from a register; it is glitch-free.

Test Plan (ON_CYCLES=4, OFF_CYCLES=3, MAX_PENDING=2):
- Single event: reset, then a 1-cycle trigger at edge 10 -> out=1 at edges 11..14, 0 from 15; busy=1 at 11..17, busy=0 at 18; pending stays 0.
- Held trigger: trigger high for 3 consecutive cycles from idle -> first starts the pulse, next two give pending=2. Pulses at 11..14, 18..21, 25..28 with exactly 3 low cycles between; pending reads 2, 1, 0 across dequeues; overflow=0.
- Overflow: trigger held 5 cycles from idle -> pending saturates at 2, overflow=1 from the 4th trigger cycle onward; exactly 3 pulses are produced; overflow stays 1 after IDLE until reset.
- Simultaneous dequeue: pending=2 saturated, trigger asserted exactly on the final GAP cycle -> pending remains 2 (dequeue+enqueue), overflow unchanged 0.
- Reset mid-operation: reset asserted at the 2nd HIGH cycle with pending=1 -> next edge out=0, busy=0, pending=0, overflow=0; no further pulses.
- Gap-boundary trigger: trigger on the last GAP cycle with pending=0 -> IDLE for one cycle, then HIGH; next pulse starts 2 edges after the gap ends; total low time = 4 cycles.
